// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: drives the PC controls and the imem request handshake, and buffers one instruction across decode stalls.
// Optional FETCH_PERF_EN adds the stall_cnt/redirect_cnt performance counters.
module fetch_seq_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic              jal_hit,
  input  logic              id_stall,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              pc_stop,
  output logic              pc_op1,
  output logic              pc_op2,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  output logic              flush_if,
`ifdef FETCH_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       redirect_cnt,
`endif
  output logic              flush_id
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          boot_q, boot_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                live, redirect, accepted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      boot_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    boot_d   = boot_q;
    hold_d   = hold_q;
    imem_req = 1'b0;
    if_instr = '0;
    accepted = 1'b0;

    // Redirects are only honoured once fetching has started.
    live     = (state_q != IDLE);
    redirect = live & (branch_taken | jal_hit);
    pc_op1   = live & branch_taken;
    pc_op2   = live & jal_hit & ~branch_taken;
    flush_if = redirect;
    flush_id = live & branch_taken;

    case (state_q)
      IDLE: begin
        if (boot_q == 4'(BOOT_DELAY - 1)) begin
          state_d = FETCH;
          boot_d  = '0;
        end else begin
          boot_d = boot_q + 4'd1;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if_instr = imem_rdata;
        if (imem_ack) begin
          if (!redirect) begin
            if (id_stall) begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              accepted = 1'b1;
            end
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The outstanding request belongs to the old PC; its data is dropped.
        imem_req = 1'b1;
        if (imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if_instr = hold_q;
        if (redirect) begin
          hold_d  = '0;
          state_d = FETCH;
        end else if (!id_stall) begin
          accepted = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if_valid = accepted | ((state_q == HOLD) & ~redirect);
    pc_stop  = ~(redirect | accepted);
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (live && pc_stop) stall_cnt <= stall_cnt + 32'd1;
      if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: a transaction-level model checked every cycle plus literal pins.
module tb_fetch_seq_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned BD = 2;

  logic          clk = 1'b0;
  logic          rst, branch_taken, jal_hit, id_stall, imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          imem_req, pc_stop, pc_op1, pc_op2, if_valid, flush_if, flush_id;
  logic [DW-1:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0]   stall_cnt, redirect_cnt;
`endif

  fetch_seq_ctrl #(.DATA_W(DW), .BOOT_DELAY(BD)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jal_hit(jal_hit),
    .id_stall(id_stall), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc_stop(pc_stop), .pc_op1(pc_op1), .pc_op2(pc_op2),
    .if_instr(if_instr), .if_valid(if_valid), .flush_if(flush_if),
`ifdef FETCH_PERF_EN
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt),
`endif
    .flush_id(flush_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk     = 1'b0;

  // Model: remaining boot cycles, a held instruction, or a stale request in flight.
  int unsigned   m_boot = BD;
  bit            m_held = 1'b0, m_stale = 1'b0;
  logic [DW-1:0] m_buf  = '0;
  logic [31:0]   m_stalls = '0, m_redirs = '0;

  logic s_req, s_stop, s_op1, s_op2, s_fi, s_fid, s_valid;
  logic [DW-1:0] s_instr;

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic j, input logic s,
                      input logic a, input logic [DW-1:0] d);
    bit act, e_redir, e_acc, e_valid, e_stop;
    logic [6:0] e_vec, a_vec;
    logic [DW-1:0] e_instr;
    rst = r; branch_taken = b; jal_hit = j; id_stall = s; imem_ack = a; imem_rdata = d;
    act     = (m_boot == 0);
    e_redir = act & (b | j);
    e_acc   = act & ~s & ~e_redir & (m_held | (~m_stale & a));
    e_valid = e_acc | (act & m_held & ~e_redir);
    e_stop  = ~(e_redir | e_acc);
    e_instr = m_held ? m_buf : d;
    e_vec   = {act & ~m_held, e_stop, act & b, act & j & ~b, e_redir, act & b, e_valid};
    @(negedge clk);
    s_req = imem_req; s_stop = pc_stop; s_op1 = pc_op1; s_op2 = pc_op2;
    s_fi = flush_if; s_fid = flush_id; s_valid = if_valid; s_instr = if_instr;
    a_vec = {s_req, s_stop, s_op1, s_op2, s_fi, s_fid, s_valid};
    if (chk) begin
      vectors++;
      if (a_vec !== e_vec || (e_valid && s_instr !== e_instr)) begin
        errors++;
        $display("FAIL cycle t=%0t {req,stop,op1,op2,fif,fid,vld}: got %b/%h expected %b/%h",
                 $time, a_vec, s_instr, e_vec, e_instr);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if (stall_cnt !== m_stalls || redirect_cnt !== m_redirs) begin
        errors++;
        $display("FAIL perf t=%0t: got stall=%0d redir=%0d expected stall=%0d redir=%0d",
                 $time, stall_cnt, redirect_cnt, m_stalls, m_redirs);
      end
`endif
    end
    @(posedge clk);
    if (!r) begin
      m_boot = BD; m_held = 1'b0; m_stale = 1'b0; m_stalls = '0; m_redirs = '0;
    end else begin
      if (act && e_stop) m_stalls = m_stalls + 32'd1;
      if (e_redir) m_redirs = m_redirs + 32'd1;
      if (!act) m_boot--;
      else if (m_held) begin
        if (e_redir || !s) m_held = 1'b0;
      end else if (m_stale) begin
        if (a) m_stale = 1'b0;
      end else if (a) begin
        if (!e_redir && s) begin m_held = 1'b1; m_buf = d; end
      end else if (e_redir) m_stale = 1'b1;
    end
    #1;
  endtask

  initial begin
    step(0,0,0,0,0,'0);
    chk = 1'b1;
    step(0,0,0,0,0,'0);
    pin("rst_req", 32'(s_req), 0); pin("rst_stop", 32'(s_stop), 1); pin("rst_valid", 32'(s_valid), 0);
    step(1,1,0,0,1,32'hDEAD);
    pin("idle_op1", 32'(s_op1), 0); pin("idle_flush", 32'(s_fi), 0); pin("idle_stop", 32'(s_stop), 1);
    step(1,0,0,0,0,'0);
    pin("boot_req", 32'(s_req), 0);
    step(1,0,0,0,0,'0);
    pin("req_rise", 32'(s_req), 1);
    step(1,0,0,0,1,32'h00000013);
    pin("ack_valid", 32'(s_valid), 1); pin("ack_instr", s_instr, 32'h00000013);
    pin("ack_stop", 32'(s_stop), 0); pin("ack_op", {30'd0, s_op1, s_op2}, 0);
    step(1,0,0,0,0,'0);
    pin("wait_stop", 32'(s_stop), 1);
    step(1,0,0,0,1,32'h00100113);
    // decode stall across a returned instruction
    step(1,0,0,0,0,'0);
    step(1,0,0,1,1,32'h00A00093);
    pin("stall_ack_stop", 32'(s_stop), 1);
    step(1,0,0,1,0,'0);
    pin("hold_req", 32'(s_req), 0); pin("hold_valid", 32'(s_valid), 1);
    pin("hold_instr", s_instr, 32'h00A00093); pin("hold_stop", 32'(s_stop), 1);
    step(1,0,0,1,0,'0);
    step(1,0,0,0,0,'0);
    pin("release_stop", 32'(s_stop), 0); pin("release_valid", 32'(s_valid), 1);
    step(1,0,0,0,0,'0);
    pin("release_req", 32'(s_req), 1);
    // branch and jal together with a fetch outstanding
    step(1,1,1,0,0,'0);
    pin("dual_op", {30'd0, s_op1, s_op2}, 2); pin("dual_stop", 32'(s_stop), 0);
    pin("dual_flush", {30'd0, s_fi, s_fid}, 3);
    step(1,0,0,0,0,'0);
    pin("drop_req", 32'(s_req), 1); pin("drop_valid", 32'(s_valid), 0);
    step(1,0,1,0,0,'0);
    step(1,0,0,0,1,32'h00000BAD);
    pin("drop_ack_valid", 32'(s_valid), 0);
    step(1,0,0,0,0,'0);
    pin("after_drop_req", 32'(s_req), 1);
    step(1,0,0,0,1,32'h00200193);
    // jal while holding
    step(1,0,0,0,0,'0);
    step(1,0,0,1,1,32'h00300213);
    step(1,0,1,1,0,'0);
    pin("hold_jal_op2", 32'(s_op2), 1); pin("hold_jal_flush", {30'd0, s_fi, s_fid}, 2);
    pin("hold_jal_valid", 32'(s_valid), 0); pin("hold_jal_stop", 32'(s_stop), 0);
    step(1,0,0,0,0,'0);
    pin("hold_jal_req", 32'(s_req), 1);
    // redirect coinciding with ack
    step(1,0,1,0,1,32'h00000BAD);
    pin("ack_redir_valid", 32'(s_valid), 0);
    step(1,1,0,1,1,32'h00000BAD);
    step(1,0,0,0,0,'0);
    pin("ack_redir_req", 32'(s_req), 1);
    step(1,0,0,0,1,32'h00400293);
    // reset while a stale request is outstanding
    step(1,0,1,0,0,'0);
    step(0,0,0,0,0,'0);
    step(0,0,0,0,1,32'h00000BAD);
    pin("rst_drop_req", 32'(s_req), 0); pin("rst_drop_stop", 32'(s_stop), 1);
    step(1,0,0,0,1,32'h00000BAD);
    pin("late_ack_valid", 32'(s_valid), 0);
    step(1,0,0,0,0,'0);
    step(1,0,0,0,0,'0);
    pin("restart_req", 32'(s_req), 1);
    step(1,0,0,0,1,32'h00500313);
    step(1,0,0,0,0,'0);
    step(1,0,0,1,1,32'h00600393);
    step(1,0,0,1,0,'0);
    step(1,1,0,0,0,'0);
    step(1,0,0,0,1,32'h00700413);
    step(1,0,0,0,0,'0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1);
  end
endmodule
